seq_sched: RTL

//  Programmable scheduler for the counted-repeat sequence datapath: each value v in [lo..hi]
//  is emitted v times (mode 0) or cfg_rep times (mode 1), e.g. 1,2,2,3,3,3.

---
 rtl/seq_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seq_sched.sv
// ---------------------------------------------------------------------------
// seq_sched
//
// Programmable scheduler for the counted-repeat sequence datapath. For every
// value v in [lo..hi] the block emits v beats of value v (mode 0) or cfg_rep
// beats of value v (mode 1), e.g. lo=1, hi=3, mode 0 -> 1,2,2,3,3,3.
// A run is started with a start pulse, can be cut short with abort, may loop
// back from hi to lo, and respects valid/ready backpressure on the output.
//
// Parameters
//   W          width of sequence values (cfg_lo, cfg_hi, out_data)
//   CW         width of the repeat counter and cfg_rep (CW >= W)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   start      pulse, starts a run (honoured only while idle)
//   abort      terminates a run from CHECK, RUN or DONE
//   cfg_lo     first value of the range
//   cfg_hi     last value of the range
//   cfg_rep    repeat count per value in mode 1
//   cfg_mode   0: repeat = value, 1: repeat = cfg_rep
//   cfg_loop   1: wrap from hi back to the first value until abort
//   out_data   current sequence value
//   out_valid  out_data carries a beat
//   out_ready  consumer accepts the beat this cycle
//   busy       high in CHECK, RUN and DONE
//   done       one-cycle pulse on normal completion
//   err        one-cycle pulse when the configuration is rejected
// ---------------------------------------------------------------------------
module seq_sched #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  cfg_lo,
    input  logic [W-1:0]  cfg_hi,
    input  logic [CW-1:0] cfg_rep,
    input  logic          cfg_mode,
    input  logic          cfg_loop,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;

    logic [W-1:0]  lo_q;
    logic [W-1:0]  hi_q;
    logic [CW-1:0] rep_q;
    logic          mode_q;
    logic          loop_q;

    logic [W-1:0]  cur;
    logic [CW-1:0] rem;

    logic [W-1:0]  first_val;
    logic [W-1:0]  next_val;
    logic          beat;

    // A configuration is unusable when the range is empty, when mode 1 asks
    // for zero repeats, or when mode 0 has no non-zero value to emit.
    function automatic logic cfg_bad(input logic [W-1:0]  lo,
                                     input logic [W-1:0]  hi,
                                     input logic [CW-1:0] rep,
                                     input logic          mode);
        return (lo > hi) || (mode && (rep == '0)) || (!mode && (hi == '0));
    endfunction

    // Number of beats for value v under the latched configuration.
    function automatic logic [CW-1:0] rep_of(input logic [W-1:0]  v,
                                             input logic          mode,
                                             input logic [CW-1:0] rep);
        return mode ? rep : CW'(v);
    endfunction

    // Mode 0 would give value 0 zero beats, so a range starting at 0 really
    // starts at 1. next_val never wraps because it is only used when cur<hi.
    always_comb begin
        first_val = lo_q;
        if (!mode_q && (lo_q == '0)) begin
            first_val = W'(1);
        end
        next_val = cur + W'(1);
        beat     = out_valid && out_ready;
    end

    // Control FSM with all outputs registered. The configuration check is
    // also evaluated on the accepted start edge so that err is already
    // visible in the CHECK cycle; CHECK re-evaluates it from the shadow
    // registers to decide between RUN and IDLE. abort overrides both start
    // and a beat transfer in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            rep_q     <= '0;
            mode_q    <= 1'b0;
            loop_q    <= 1'b0;
            cur       <= '0;
            rem       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    if (start && !abort) begin
                        lo_q   <= cfg_lo;
                        hi_q   <= cfg_hi;
                        rep_q  <= cfg_rep;
                        mode_q <= cfg_mode;
                        loop_q <= cfg_loop;
                        busy   <= 1'b1;
                        err    <= cfg_bad(cfg_lo, cfg_hi, cfg_rep, cfg_mode);
                        state  <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    err <= 1'b0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cfg_bad(lo_q, hi_q, rep_q, mode_q)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cur       <= first_val;
                        out_data  <= first_val;
                        rem       <= rep_of(first_val, mode_q, rep_q);
                        out_valid <= 1'b1;
                        state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (beat) begin
                        if (rem > CW'(1)) begin
                            rem <= rem - CW'(1);
                        end else if (cur < hi_q) begin
                            cur      <= next_val;
                            out_data <= next_val;
                            rem      <= rep_of(next_val, mode_q, rep_q);
                        end else if (loop_q) begin
                            cur      <= first_val;
                            out_data <= first_val;
                            rem      <= rep_of(first_val, mode_q, rep_q);
                        end else begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
